counter_timer_bank: RTL and testbench
=====================================

# counter_timer_bank

Parametrised counter/timer bank for the BlackJack datapath, single-clock on `clk_50M`. It provides N independent card/score counters and one delay timer generating the FSM's `o_TwoSec` pulse. The timer uses an internal prescaler instead of a separate 2 kHz clock domain. It sits between the game FSM and the display/score logic.

## Interface
- `WIDTH`, default 12: bits per channel counter.
- `N_CH`, default 4: number of counter channels.
- `CLK_HZ`, default 50_000_000: system clock frequency.
- `TICK_HZ`, default 2000: timer tick rate. `DIV = CLK_HZ/TICK_HZ` must be ≥ 2 and an exact integer.
- `TIMEOUT_TICKS`, default 4000: ticks per timer run (2 s at defaults). Must be ≥ 1.
- `SATURATE`, default 1: 1 = counters hold at max; 0 = counters wrap to 0.
- `clk_50M`  in  1: system clock. All logic is on the rising edge.
- `i_Reset_n`  in  1: reset, synchronous, active-low.
- `i_Inc`  in  N_CH: per-channel increment enable, one step per cycle while high.
- `i_Zero`  in  N_CH: per-channel synchronous clear.
- `o_Count`  out  N_CH*WIDTH: channel k occupies bits [k*WIDTH +: WIDTH].
- `o_Max`  out  N_CH: channel count equals 2^WIDTH−1.
- `i_TwoSec`  in  1: timer start request from the FSM.
- `i_Abort`  in  1: cancel the running timer.
- `o_TwoSec`  out  1: one-cycle done pulse.
- `o_Busy`  out  1: timer is in RUN.
- `o_Tick`  out  1: prescaler tick pulse, only during RUN.

## Operation
- Reset (`i_Reset_n` = 0 at an edge) sets:
  - all counts to 0, `o_Max` to 0;
  - timer state to IDLE, prescaler and tick counter to 0;
  - `o_TwoSec`, `o_Busy` and `o_Tick` to 0.
- Reset has priority over every other input, including in mid-run.
- Channel k update priority: `i_Zero[k]` (count ← 0), then `i_Inc[k]` (count + 1), otherwise hold.
- Channel k at max with `i_Inc[k]` high:
  - `SATURATE=1`: stays at 2^WIDTH−1.
  - `SATURATE=0`: wraps to 0.
- Channels are fully independent. Simultaneous activity on different channels never interacts.
- Timer FSM has three states: IDLE, RUN, DONE.
  - IDLE → RUN when `i_TwoSec`=1 and `i_Abort`=0. On entry, prescaler and tick counter are cleared to 0.
  - RUN: prescaler counts 0..DIV−1. At DIV−1 it returns to 0 and the tick counter increments.
  - RUN → DONE when prescaler = DIV−1 and tick counter = TIMEOUT_TICKS−1.
  - RUN → IDLE when `i_Abort`=1. Abort has priority over completion in the same cycle; no `o_TwoSec` pulse is produced.
  - `i_TwoSec` during RUN is ignored (no retrigger).
  - DONE lasts exactly one cycle. It goes to RUN if `i_TwoSec`=1 and `i_Abort`=0 that cycle (back-to-back run); otherwise to IDLE.
- Output decodes:
  - `o_TwoSec` = (state == DONE).
  - `o_Busy` = (state == RUN).
  - `o_Tick` = RUN and prescaler = DIV−1.
- Widths:
  - prescaler is $clog2(DIV) bits;
  - tick counter is $clog2(TIMEOUT_TICKS+1) bits;
  - comparisons are unsigned and zero-extended.

## Timing
- Counter latency: 1 cycle. Input sampled at edge t gives the new `o_Count` after edge t.
- `o_Max` is combinational from the count register, so it is valid in the same cycle as `o_Count`.
- Timer latency: start sampled at edge t0 puts `o_TwoSec` high for exactly the cycle following edge t0 + TIMEOUT_TICKS·DIV.
  - At defaults this is 100_000_000 cycles (2.000 s).
- `o_Busy` rises the cycle after the start edge and falls in the cycle `o_TwoSec` rises.
- Within one run, `o_Tick` pulses TIMEOUT_TICKS times, spaced DIV cycles apart. The first pulse is in the cycle after edge t0 + DIV − 1.
- Back-to-back operation: start held high continuously gives `o_TwoSec` pulses every TIMEOUT_TICKS·DIV + 1 cycles.

## Structure
- Shared package `bj_pkg` holds:
  - the timer state enum (IDLE/RUN/DONE);
  - the default constants CLK_HZ, TICK_HZ, TIMEOUT_TICKS and WIDTH.
- Sub-module `counter_channel` (one register with clear/inc/saturate) is instantiated N_CH times by a generate loop.
- Timer FSM and prescaler stay in the top module.

## Test plan
Bench parameters: `CLK_HZ`=20, `TICK_HZ`=5 (DIV=4), `TIMEOUT_TICKS`=3, `WIDTH`=4, `N_CH`=2.
- Reset check: hold `i_Reset_n`=0 with all inputs high, then release → all outputs 0. Then pulse `i_TwoSec` one cycle → `o_Busy`=1 next cycle and `o_TwoSec` in the cycle after edge t0+12. `o_Tick` pulses exactly 3 times, 4 cycles apart.
- Saturate vs wrap:
  - `SATURATE=1`, `i_Inc[0]` held 20 cycles → ch0 reaches 15 and stays; `o_Max[0]`=1.
  - `SATURATE=0`, same stimulus → 15→0 wrap; `o_Max[0]` high for one cycle.
- Clear priority: `i_Zero[1]`=`i_Inc[1]`=1 with ch1=7 → ch1=0 next cycle. Ch0 incrementing in parallel is unaffected.
- Abort: assert `i_Abort` 6 cycles after start → IDLE, no `o_TwoSec`. Repeat with abort on the final RUN cycle (edge t0+12) → still no pulse.
- Retrigger and back-to-back: pulse `i_TwoSec` again mid-run → done time unchanged (t0+12). Hold `i_TwoSec` high → `o_TwoSec` pulses 13 cycles apart.
- Mid-run reset: `i_Reset_n`=0 for one edge at t0+5 → `o_Busy`=0 next cycle and no `o_TwoSec` ever. All counts are 0.

Source files
------------

// File: rtl/bj_pkg.sv
// Shared definitions for the BlackJack counter/timer bank: timer state
// encoding and the default build constants.
package bj_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } timer_state_e;

   localparam int unsigned DEF_CLK_HZ        = 32'd50_000_000;
   localparam int unsigned DEF_TICK_HZ       = 32'd2000;
   localparam int unsigned DEF_TIMEOUT_TICKS = 32'd4000;
   localparam int unsigned DEF_WIDTH         = 32'd12;

endpackage : bj_pkg

// File: rtl/counter_channel.sv
// One score/card counter: synchronous clear, increment, and either
// saturation at all-ones or natural wrap to zero.
module counter_channel
   import bj_pkg::*;
#(
   parameter int unsigned WIDTH    = DEF_WIDTH,
   parameter bit          SATURATE = 1'b1
) (
   input  logic             clk_50M,
   input  logic             i_Reset_n,
   input  logic             i_Inc,
   input  logic             i_Zero,
   output logic [WIDTH-1:0] o_Count,
   output logic             o_Max
);

   localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

   logic [WIDTH-1:0] count_d;
   logic [WIDTH-1:0] count_q;
   logic             at_max;

   assign at_max = (count_q == CNT_MAX);

   // Next count: clear beats increment; at max either hold or roll over.
   always_comb begin
      count_d = count_q;
      if (i_Zero) begin
         count_d = CNT_ZERO;
      end else if (i_Inc) begin
         if (SATURATE && at_max) begin
            count_d = count_q;
         end else begin
            count_d = count_q + CNT_ONE;
         end
      end else begin
         count_d = count_q;
      end
   end

   // Count register with synchronous active-low reset.
   always_ff @(posedge clk_50M) begin
      if (!i_Reset_n) begin
         count_q <= CNT_ZERO;
      end else begin
         count_q <= count_d;
      end
   end

   assign o_Count = count_q;
   // Max flag decodes straight off the register so it lines up with o_Count.
   assign o_Max   = at_max;

endmodule : counter_channel

// File: rtl/counter_timer_bank.sv
// Counter/timer bank for the BlackJack datapath: N_CH independent counters
// plus a prescaled one-shot delay timer producing the FSM's o_TwoSec pulse.
module counter_timer_bank
   import bj_pkg::*;
#(
   parameter int unsigned WIDTH         = DEF_WIDTH,
   parameter int unsigned N_CH          = 32'd4,
   parameter int unsigned CLK_HZ        = DEF_CLK_HZ,
   parameter int unsigned TICK_HZ       = DEF_TICK_HZ,
   parameter int unsigned TIMEOUT_TICKS = DEF_TIMEOUT_TICKS,
   parameter bit          SATURATE      = 1'b1
) (
   input  logic                  clk_50M,
   input  logic                  i_Reset_n,
   input  logic [N_CH-1:0]       i_Inc,
   input  logic [N_CH-1:0]       i_Zero,
   output logic [N_CH*WIDTH-1:0] o_Count,
   output logic [N_CH-1:0]       o_Max,
   input  logic                  i_TwoSec,
   input  logic                  i_Abort,
   output logic                  o_TwoSec,
   output logic                  o_Busy,
   output logic                  o_Tick
);

   localparam int unsigned DIV     = CLK_HZ / TICK_HZ;
   localparam int unsigned PRESC_W = (DIV > 32'd1) ? $clog2(DIV) : 32'd1;
   localparam int unsigned TICK_W  = $clog2(TIMEOUT_TICKS + 32'd1);

   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(DIV - 32'd1);
   localparam logic [PRESC_W-1:0] PRESC_ZERO = {PRESC_W{1'b0}};
   localparam logic [PRESC_W-1:0] PRESC_ONE  = PRESC_W'(1);
   localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TIMEOUT_TICKS - 32'd1);
   localparam logic [TICK_W-1:0]  TICK_ZERO  = {TICK_W{1'b0}};
   localparam logic [TICK_W-1:0]  TICK_ONE   = TICK_W'(1);

   // ---------------------------------------------------------------
   // Counter channels
   // ---------------------------------------------------------------
   for (genvar k = 0; k < N_CH; k++) begin : g_ch
      counter_channel #(
         .WIDTH    (WIDTH),
         .SATURATE (SATURATE)
      ) u_ch (
         .clk_50M   (clk_50M),
         .i_Reset_n (i_Reset_n),
         .i_Inc     (i_Inc[k]),
         .i_Zero    (i_Zero[k]),
         .o_Count   (o_Count[k*WIDTH +: WIDTH]),
         .o_Max     (o_Max[k])
      );
   end

   // ---------------------------------------------------------------
   // Delay timer
   // ---------------------------------------------------------------
   timer_state_e         state_d,    state_q;
   logic [PRESC_W-1:0]   presc_d,    presc_q;
   logic [TICK_W-1:0]    tick_cnt_d, tick_cnt_q;
   logic                 two_sec_d,  two_sec_q;
   logic                 busy_d,     busy_q;
   logic                 tick_out_d, tick_out_q;
   logic                 start_ok;

   assign start_ok = i_TwoSec && !i_Abort;

   // Timer next state: abort wins over completion; DONE may relaunch a run.
   always_comb begin
      state_d    = state_q;
      presc_d    = presc_q;
      tick_cnt_d = tick_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (start_ok) begin
               state_d    = ST_RUN;
               presc_d    = PRESC_ZERO;
               tick_cnt_d = TICK_ZERO;
            end else begin
               state_d    = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (i_Abort) begin
               state_d = ST_IDLE;
            end else if (presc_q == PRESC_LAST) begin
               presc_d = PRESC_ZERO;
               if (tick_cnt_q == TICK_LAST) begin
                  state_d = ST_DONE;
               end else begin
                  tick_cnt_d = tick_cnt_q + TICK_ONE;
               end
            end else begin
               presc_d = presc_q + PRESC_ONE;
            end
         end
         ST_DONE: begin
            if (start_ok) begin
               state_d    = ST_RUN;
               presc_d    = PRESC_ZERO;
               tick_cnt_d = TICK_ZERO;
            end else begin
               state_d    = ST_IDLE;
            end
         end
         default: begin
            state_d    = ST_IDLE;
            presc_d    = PRESC_ZERO;
            tick_cnt_d = TICK_ZERO;
         end
      endcase
      // Outputs are decoded from the next state so they register in step
      // with the state they describe.
      two_sec_d  = (state_d == ST_DONE);
      busy_d     = (state_d == ST_RUN);
      tick_out_d = busy_d && (presc_d == PRESC_LAST);
   end

   // Timer FSM, prescaler, tick counter and registered outputs.
   always_ff @(posedge clk_50M) begin
      if (!i_Reset_n) begin
         state_q    <= ST_IDLE;
         presc_q    <= PRESC_ZERO;
         tick_cnt_q <= TICK_ZERO;
         two_sec_q  <= 1'b0;
         busy_q     <= 1'b0;
         tick_out_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         presc_q    <= presc_d;
         tick_cnt_q <= tick_cnt_d;
         two_sec_q  <= two_sec_d;
         busy_q     <= busy_d;
         tick_out_q <= tick_out_d;
      end
   end

   assign o_TwoSec = two_sec_q;
   assign o_Busy   = busy_q;
   assign o_Tick   = tick_out_q;

endmodule : counter_timer_bank

// File: tb/tb_counter_timer_bank.sv
// Bench for counter_timer_bank: a saturating and a wrapping instance share
// stimulus; a cycle model pushes expectations that are popped after each edge.
module tb_counter_timer_bank;

   localparam int RUN_CYC = 12;   // TIMEOUT_TICKS * DIV
   localparam int DIV_CYC = 4;

   logic       clk_50M;
   logic       i_Reset_n;
   logic [1:0] i_Inc;
   logic [1:0] i_Zero;
   logic       i_TwoSec;
   logic       i_Abort;

   logic [7:0] sat_count,  wrap_count;
   logic [1:0] sat_max,    wrap_max;
   logic       sat_two,    wrap_two;
   logic       sat_busy,   wrap_busy;
   logic       sat_tick,   wrap_tick;

   counter_timer_bank #(
      .WIDTH(4), .N_CH(2), .CLK_HZ(20), .TICK_HZ(5), .TIMEOUT_TICKS(3), .SATURATE(1'b1)
   ) dut_sat (
      .clk_50M(clk_50M), .i_Reset_n(i_Reset_n), .i_Inc(i_Inc), .i_Zero(i_Zero),
      .o_Count(sat_count), .o_Max(sat_max), .i_TwoSec(i_TwoSec), .i_Abort(i_Abort),
      .o_TwoSec(sat_two), .o_Busy(sat_busy), .o_Tick(sat_tick)
   );

   counter_timer_bank #(
      .WIDTH(4), .N_CH(2), .CLK_HZ(20), .TICK_HZ(5), .TIMEOUT_TICKS(3), .SATURATE(1'b0)
   ) dut_wrap (
      .clk_50M(clk_50M), .i_Reset_n(i_Reset_n), .i_Inc(i_Inc), .i_Zero(i_Zero),
      .o_Count(wrap_count), .o_Max(wrap_max), .i_TwoSec(i_TwoSec), .i_Abort(i_Abort),
      .o_TwoSec(wrap_two), .o_Busy(wrap_busy), .o_Tick(wrap_tick)
   );

   initial begin
      clk_50M = 1'b0;
      forever #5 clk_50M = ~clk_50M;
   end

   typedef struct {
      logic [7:0] cnt_sat;
      logic [7:0] cnt_wrap;
      logic [1:0] max_sat;
      logic [1:0] max_wrap;
      logic       busy;
      logic       two;
      logic       tick;
   } exp_t;

   exp_t sb_q[$];
   int   done_q[$];
   int   tick_q[$];

   int n_checks = 0;
   int n_errors = 0;
   int edge_n   = 0;

   // reference model state
   int m_sat[2];
   int m_wrap[2];
   int m_st;       // 0 idle, 1 run, 2 done
   int m_el;       // cycles elapsed since the start edge

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, edge_n);
      end
   endtask

   task automatic model_update();
      if (!i_Reset_n) begin
         m_st = 0;
         m_el = 0;
         for (int k = 0; k < 2; k++) begin
            m_sat[k]  = 0;
            m_wrap[k] = 0;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            if (i_Zero[k]) begin
               m_sat[k]  = 0;
               m_wrap[k] = 0;
            end else if (i_Inc[k]) begin
               m_sat[k]  = (m_sat[k] == 15) ? 15 : m_sat[k] + 1;
               m_wrap[k] = (m_wrap[k] + 1) % 16;
            end
         end
         case (m_st)
            0: if (i_TwoSec && !i_Abort) begin m_st = 1; m_el = 0; end
            1: if (i_Abort) m_st = 0;
               else begin
                  m_el++;
                  if (m_el == RUN_CYC) m_st = 2;
               end
            default: if (i_TwoSec && !i_Abort) begin m_st = 1; m_el = 0; end
                     else m_st = 0;
         endcase
      end
   endtask

   // One clock: model the edge, queue the expectation, compare after the edge.
   task automatic step();
      exp_t e;
      exp_t g;
      model_update();
      e.cnt_sat  = {m_sat[1][3:0], m_sat[0][3:0]};
      e.cnt_wrap = {m_wrap[1][3:0], m_wrap[0][3:0]};
      e.max_sat  = {m_sat[1] == 15, m_sat[0] == 15};
      e.max_wrap = {m_wrap[1] == 15, m_wrap[0] == 15};
      e.busy     = (m_st == 1);
      e.two      = (m_st == 2);
      e.tick     = (m_st == 1) && ((m_el % DIV_CYC) == DIV_CYC - 1);
      sb_q.push_back(e);
      @(posedge clk_50M);
      #1;
      edge_n++;
      g = sb_q.pop_front();
      check_eq("sat_count",  sat_count,  g.cnt_sat);
      check_eq("wrap_count", wrap_count, g.cnt_wrap);
      check_eq("sat_max",    sat_max,    g.max_sat);
      check_eq("wrap_max",   wrap_max,   g.max_wrap);
      check_eq("busy",       {sat_busy, wrap_busy}, {g.busy, g.busy});
      check_eq("two_sec",    {sat_two,  wrap_two},  {g.two,  g.two});
      check_eq("tick",       {sat_tick, wrap_tick}, {g.tick, g.tick});
      if (sat_two)  done_q.push_back(edge_n);
      if (sat_tick) tick_q.push_back(edge_n);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic clear_mon();
      done_q.delete();
      tick_q.delete();
   endtask

   int e0;
   int wrap_max_n;

   initial begin
      // Reset with every input high.
      i_Reset_n = 1'b0; i_Inc = 2'b11; i_Zero = 2'b11; i_TwoSec = 1'b1; i_Abort = 1'b1;
      run(3);
      i_Reset_n = 1'b1; i_Inc = 2'b00; i_Zero = 2'b00; i_TwoSec = 1'b0; i_Abort = 1'b0;
      step();
      check_eq("rst_outputs", {sat_count, sat_max, sat_two, sat_busy, sat_tick}, 32'd0);

      // Single timer run.
      clear_mon();
      i_TwoSec = 1'b1; step(); e0 = edge_n; i_TwoSec = 1'b0;
      step();
      check_eq("busy_after_start", sat_busy, 1'b1);
      run(16);
      check_eq("run_done_n", done_q.size(), 1);
      if (done_q.size() == 1) check_eq("run_done_at", done_q[0] - e0, RUN_CYC);
      check_eq("run_tick_n", tick_q.size(), 3);
      for (int i = 0; i < tick_q.size(); i++)
         check_eq("run_tick_at", tick_q[i] - e0, DIV_CYC * i + DIV_CYC - 1);

      // Saturate vs wrap on ch0.
      wrap_max_n = 0;
      i_Inc = 2'b01;
      for (int i = 0; i < 20; i++) begin
         step();
         if (wrap_max[0]) wrap_max_n++;
      end
      check_eq("sat_hold15", sat_count[3:0], 4'd15);
      check_eq("sat_max0",   sat_max[0], 1'b1);
      check_eq("wrap_val",   wrap_count[3:0], 4'd4);
      check_eq("wrap_max_n", wrap_max_n, 1);
      i_Inc = 2'b00; i_Zero = 2'b01; step(); i_Zero = 2'b00;

      // Clear priority on ch1 while ch0 increments.
      i_Inc = 2'b10; run(7);
      check_eq("ch1_at7", sat_count[7:4], 4'd7);
      i_Inc = 2'b11; i_Zero = 2'b10; step();
      check_eq("ch1_cleared", sat_count[7:4], 4'd0);
      check_eq("ch0_parallel", sat_count[3:0], 4'd1);
      i_Inc = 2'b00; i_Zero = 2'b11; step(); i_Zero = 2'b00;

      // Abort six cycles after start.
      clear_mon();
      i_TwoSec = 1'b1; step(); i_TwoSec = 1'b0;
      run(5);
      i_Abort = 1'b1; step(); i_Abort = 1'b0;
      check_eq("abort6_busy", sat_busy, 1'b0);
      run(15);
      check_eq("abort6_no_done", done_q.size(), 0);

      // Abort on the final RUN edge.
      clear_mon();
      i_TwoSec = 1'b1; step(); i_TwoSec = 1'b0;
      run(11);
      i_Abort = 1'b1; step(); i_Abort = 1'b0;
      run(6);
      check_eq("abort_last_no_done", done_q.size(), 0);

      // Retrigger mid-run does not move the done time.
      clear_mon();
      i_TwoSec = 1'b1; step(); e0 = edge_n; i_TwoSec = 1'b0;
      run(4);
      i_TwoSec = 1'b1; step(); i_TwoSec = 1'b0;
      run(14);
      check_eq("retrig_done_n", done_q.size(), 1);
      if (done_q.size() == 1) check_eq("retrig_done_at", done_q[0] - e0, RUN_CYC);

      // Back-to-back with start held high.
      clear_mon();
      i_TwoSec = 1'b1; step(); e0 = edge_n;
      run(39);
      i_TwoSec = 1'b0;
      run(15);
      check_eq("b2b_done_n", done_q.size(), 4);
      if (done_q.size() > 0) check_eq("b2b_first", done_q[0] - e0, RUN_CYC);
      for (int i = 1; i < done_q.size(); i++)
         check_eq("b2b_spacing", done_q[i] - done_q[i-1], RUN_CYC + 1);

      // Reset in the middle of a run.
      i_Inc = 2'b11; run(3); i_Inc = 2'b00;
      check_eq("pre_rst_count", sat_count, 8'h33);
      clear_mon();
      i_TwoSec = 1'b1; step(); i_TwoSec = 1'b0;
      run(4);
      i_Reset_n = 1'b0; step(); i_Reset_n = 1'b1;
      check_eq("midrst_busy", sat_busy, 1'b0);
      check_eq("midrst_count", {sat_count, wrap_count}, 16'h0000);
      run(15);
      check_eq("midrst_no_done", done_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_counter_timer_bank
